// File: rtl/ecall_controller_pkg.sv
// Shared constants and types for the environment-call controller.
package ecall_controller_pkg;

  localparam logic [6:0]  OPC_SYSTEM    = 7'b1110011;
  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_WAIT_RELEASE = 3'd2,
    ST_WRITEBACK    = 3'd3,
    ST_HALT         = 3'd4
  } state_t;

endpackage

// File: rtl/ecall_controller_if.sv
// Signal bundle between the CPU/front panel and the ecall controller.
// Handshake: the controller samples ecall_valid/a7/a0 on every rising clk
// edge; while stall is high the CPU holds the same ecall presented. rf_we and
// disp_valid are single-cycle strobes qualifying rf_waddr/rf_wdata and
// disp_data respectively; there is no back-pressure on either.
interface ecall_controller_if;
  import ecall_controller_pkg::*;

  logic        ecall_valid;
  logic [31:0] a7;
  logic [31:0] a0;
  logic        confirm;
  logic [7:0]  sw;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        halted;
  logic        busy;
  state_t      dbg_state;

  modport master (
    output ecall_valid, a7, a0, confirm, sw,
    input  stall, rf_we, rf_waddr, rf_wdata, disp_data, disp_valid,
           halted, busy, dbg_state
  );

  modport slave (
    input  ecall_valid, a7, a0, confirm, sw,
    output stall, rf_we, rf_waddr, rf_wdata, disp_data, disp_valid,
           halted, busy, dbg_state
  );
endinterface

// File: rtl/ecall_controller_button_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter and one-cycle
// press/release pulses on the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          press_q, release_q;

  // Synchronize, count consecutive disagreement, flip the stable level on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q     <= '0;
        stable_q  <= ~stable_q;
        press_q   <= ~stable_q;
        release_q <= stable_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/ecall_controller.sv
// Environment-call sequencer: print, operator-confirmed switch read with a0
// write-back, and sticky halt. Owns the pipeline stall line.
module ecall_controller
  import ecall_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int A0_INDEX        = 10
) (
  input logic               clk,
  input logic               rst,
  ecall_controller_if.slave bus
);
  state_t      state_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] disp_data_q;
  logic        disp_valid_q;
  logic        press_edge, release_edge;
  logic        idle, svc_blocking;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (bus.confirm),
    .press_o   (press_edge),
    .release_o (release_edge)
  );

  // Service sequencing; a held button never produces press_edge, so entry
  // into WAIT_PRESS always needs a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rf_wdata_q   <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ecall_valid) begin
            if (bus.a7 == SVC_PRINT_INT) begin
              disp_data_q  <= bus.a0;
              disp_valid_q <= 1'b1;
            end else if (bus.a7 == SVC_READ_INT) begin
              state_q <= ST_WAIT_PRESS;
            end else if (bus.a7 == SVC_EXIT) begin
              state_q <= ST_HALT;
            end
          end
        end
        ST_WAIT_PRESS:   if (press_edge) state_q <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: begin
          if (release_edge) begin
            rf_wdata_q <= {24'b0, bus.sw};
            state_q    <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK:    state_q <= ST_IDLE;
        ST_HALT:         state_q <= ST_HALT;
        default:         state_q <= ST_IDLE;
      endcase
    end
  end

  // Blocking services stall in the very cycle they are decoded
  assign idle         = (state_q == ST_IDLE);
  assign svc_blocking = (bus.a7 == SVC_READ_INT) || (bus.a7 == SVC_EXIT);

  assign bus.stall      = !idle || (bus.ecall_valid && svc_blocking);
  assign bus.rf_we      = (state_q == ST_WRITEBACK);
  assign bus.rf_waddr   = 5'(A0_INDEX);
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.busy       = !idle;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_ecall_controller.sv
// Self-checking bench for ecall_controller with a short debounce window.
module tb_ecall_controller;
  import ecall_controller_pkg::*;

  localparam int DEB = 4;
  // 2 synchronizer edges + DEB counting edges + 1 FSM edge
  localparam int REL_TO_WE = DEB + 3;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   rf_we_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] disp_q[$];

  ecall_controller_if bus();

  ecall_controller #(.DEBOUNCE_CYCLES(DEB), .A0_INDEX(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_ecall(input logic [31:0] svc, input logic [31:0] arg);
    bus.ecall_valid = 1'b1;
    bus.a7 = svc;
    bus.a0 = arg;
  endtask

  task automatic idle_bus();
    bus.ecall_valid = 1'b0;
    bus.a7 = 32'd0;
    bus.a0 = 32'd0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.rf_we === 1'b1) begin
      rf_we_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rf_we_unexpected: got wdata=%h, no write expected", bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_wdata !== e || bus.rf_waddr !== 5'd10)
          $display("FAIL rf_write: got addr=%0d data=%h, want addr=10 data=%h",
                   bus.rf_waddr, bus.rf_wdata, e);
        else pass_cnt++;
      end
    end
    if (bus.disp_valid === 1'b1) begin
      chk_cnt++;
      if (disp_q.size() == 0) begin
        $display("FAIL disp_unexpected: got disp_data=%h, no print expected", bus.disp_data);
      end else begin
        e = disp_q.pop_front();
        if (bus.disp_data !== e)
          $display("FAIL disp_data: got %h, want %h", bus.disp_data, e);
        else pass_cnt++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    bus.confirm = 1'b0;
    bus.sw = 8'h00;
    ticks(3);
    @(negedge clk);
    chk_cnt++;
    if ({bus.stall, bus.rf_we, bus.disp_valid, bus.halted, bus.busy} !== 5'b0 ||
        bus.disp_data !== 32'd0 || bus.rf_wdata !== 32'd0 || bus.dbg_state !== ST_IDLE)
      $display("FAIL reset_state: got stall=%b we=%b dv=%b halt=%b busy=%b dd=%h wd=%h st=%0d, want all zero/IDLE",
               bus.stall, bus.rf_we, bus.disp_valid, bus.halted, bus.busy,
               bus.disp_data, bus.rf_wdata, bus.dbg_state);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_print();
    tick();
    drive_ecall(SVC_PRINT_INT, 32'h0000_002A);
    disp_q.push_back(32'h0000_002A);
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL print_stall: got %b, want 0", bus.stall);
    else pass_cnt++;
    tick();
    idle_bus();
    @(negedge clk);
    chk_cnt++;
    if (bus.disp_valid !== 1'b1 || bus.disp_data !== 32'h2A || bus.stall !== 1'b0)
      $display("FAIL print_out: got dv=%b dd=%h stall=%b, want dv=1 dd=0000002a stall=0",
               bus.disp_valid, bus.disp_data, bus.stall);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (bus.disp_valid !== 1'b0) $display("FAIL print_pulse_width: got dv=%b, want 0", bus.disp_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom();
      tick();
      drive_ecall(SVC_PRINT_INT, v);
      disp_q.push_back(v);
    end
    // unsupported service immediately after: no stall, no print
    tick();
    drive_ecall(32'd3, 32'h1234_5678);
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL other_svc_stall: got %b, want 0", bus.stall);
    else pass_cnt++;
    tick();
    idle_bus();
    tick();
    @(negedge clk);
    chk_cnt++;
    if (disp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL back_to_back: got pending=%0d busy=%b, want 0 0", disp_q.size(), bus.busy);
    else pass_cnt++;
  endtask

  // press/release cleanly and check release-to-write latency
  task automatic clean_confirm(input string tag);
    int lat;
    logic stall_ok;
    stall_ok = 1'b1;
    bus.confirm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    tick();
    bus.confirm = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      @(negedge clk);
      if (bus.stall !== 1'b1 && bus.rf_we !== 1'b1) stall_ok = 1'b0;
      if (bus.rf_we === 1'b1) lat = i;
    end
    chk_cnt++;
    if (lat != REL_TO_WE || !stall_ok)
      $display("FAIL %s_latency: got %0d cycles stall_held=%b, want %0d cycles stall_held=1",
               tag, lat, stall_ok, REL_TO_WE);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b0 || bus.rf_we !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s_done: got stall=%b we=%b busy=%b, want 0 0 0",
               tag, bus.stall, bus.rf_we, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_read();
    tick();
    bus.sw = 8'hA5;
    drive_ecall(SVC_READ_INT, 32'd0);
    exp_q.push_back(32'h0000_00A5);
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL read_stall_same_cycle: got %b, want 1", bus.stall);
    else pass_cnt++;
    tick();
    idle_bus();
    @(negedge clk);
    chk_cnt++;
    if (bus.busy !== 1'b1 || bus.dbg_state !== ST_WAIT_PRESS)
      $display("FAIL read_enter: got busy=%b st=%0d, want busy=1 st=%0d", bus.busy, bus.dbg_state, ST_WAIT_PRESS);
    else pass_cnt++;
    clean_confirm("read");
    bus.sw = 8'h00;
  endtask

  task automatic test_bounce();
    int we0;
    tick();
    bus.sw = 8'h3C;
    drive_ecall(SVC_READ_INT, 32'd0);
    tick();
    idle_bus();
    we0 = rf_we_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.confirm = (i % 4) < 2;
      tick();
    end
    bus.confirm = 1'b0;
    ticks(8);
    @(negedge clk);
    chk_cnt++;
    if (bus.dbg_state !== ST_WAIT_PRESS || rf_we_cnt != we0 || bus.stall !== 1'b1)
      $display("FAIL bounce: got st=%0d writes=%0d stall=%b, want st=%0d writes=0 stall=1",
               bus.dbg_state, rf_we_cnt - we0, bus.stall, ST_WAIT_PRESS);
    else pass_cnt++;
    exp_q.push_back(32'h0000_003C);
    clean_confirm("bounce_recover");
  endtask

  task automatic test_held_button();
    int we0;
    tick();
    bus.confirm = 1'b1;
    ticks(10);
    bus.sw = 8'h5A;
    drive_ecall(SVC_READ_INT, 32'd0);
    exp_q.push_back(32'h0000_005A);
    we0 = rf_we_cnt;
    tick();
    idle_bus();
    ticks(3);
    bus.confirm = 1'b0;
    ticks(12);
    @(negedge clk);
    chk_cnt++;
    if (bus.dbg_state !== ST_WAIT_PRESS || rf_we_cnt != we0)
      $display("FAIL held_first_release: got st=%0d writes=%0d, want st=%0d writes=0",
               bus.dbg_state, rf_we_cnt - we0, ST_WAIT_PRESS);
    else pass_cnt++;
    clean_confirm("held");
    chk_cnt++;
    if (rf_we_cnt != we0 + 1) $display("FAIL held_write_count: got %0d, want 1", rf_we_cnt - we0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int we0;
    tick();
    bus.sw = 8'hC3;
    drive_ecall(SVC_READ_INT, 32'd0);
    we0 = rf_we_cnt;
    tick();
    idle_bus();
    bus.confirm = 1'b1;
    ticks(8);
    bus.confirm = 1'b0;
    ticks(2);
    @(negedge clk);
    chk_cnt++;
    if (bus.dbg_state !== ST_WAIT_RELEASE)
      $display("FAIL midread_state: got %0d, want %0d", bus.dbg_state, ST_WAIT_RELEASE);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.rf_we !== 1'b0)
      $display("FAIL midread_reset: got stall=%b busy=%b we=%b, want 0 0 0", bus.stall, bus.busy, bus.rf_we);
    else pass_cnt++;
    rst = 1'b0;
    ticks(20);
    @(negedge clk);
    chk_cnt++;
    if (rf_we_cnt != we0 || bus.busy !== 1'b0)
      $display("FAIL midread_no_write: got writes=%0d busy=%b, want 0 0", rf_we_cnt - we0, bus.busy);
    else pass_cnt++;
    bus.sw = 8'h00;
  endtask

  task automatic test_exit();
    logic held_ok;
    tick();
    drive_ecall(SVC_EXIT, 32'd0);
    @(negedge clk);
    chk_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL exit_stall_same_cycle: got %b, want 1", bus.stall);
    else pass_cnt++;
    held_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 3) drive_ecall(SVC_PRINT_INT, 32'hBAD0_BAD0);
      if (i == 5) idle_bus();
      @(negedge clk);
      if (bus.stall !== 1'b1 || bus.halted !== 1'b1 || bus.disp_valid !== 1'b0) held_ok = 1'b0;
    end
    chk_cnt++;
    if (!held_ok) $display("FAIL exit_sticky: got stall=%b halted=%b dv=%b, want 1 1 0",
                           bus.stall, bus.halted, bus.disp_valid);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_cnt++;
    if ({bus.stall, bus.rf_we, bus.disp_valid, bus.halted, bus.busy} !== 5'b0 ||
        bus.disp_data !== 32'd0 || bus.rf_wdata !== 32'd0)
      $display("FAIL exit_reset: got stall=%b we=%b dv=%b halt=%b busy=%b dd=%h wd=%h, want all zero",
               bus.stall, bus.rf_we, bus.disp_valid, bus.halted, bus.busy, bus.disp_data, bus.rf_wdata);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_print();
    test_back_to_back();
    test_read();
    test_bounce();
    test_held_button();
    test_reset_mid_read();
    test_exit();
    ticks(2);
    chk_cnt++;
    if (exp_q.size() != 0 || disp_q.size() != 0)
      $display("FAIL scoreboard_drain: got pending writes=%0d prints=%0d, want 0 0",
               exp_q.size(), disp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // hard stop so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
